// File: rtl/wr_req_arbiter.sv
// Round-robin arbiter sharing the CCI write-request channel between two requesters.
// Tags mdata with the requester ID, limits outstanding writes, and returns completions.
module wr_req_arbiter #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUT     = 8,
  parameter int CW          = $clog2(MAX_OUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [ADDR_LMT-1:0]    req0_addr,
  input  logic [CACHE_WIDTH-1:0] req0_data,
  input  logic [MDATA-2:0]       req0_mdata,
  output logic                   req0_ready,
  output logic [1:0]             req0_done,
  output logic [CW-1:0]          req0_outst,
  input  logic                   req1_valid,
  input  logic [ADDR_LMT-1:0]    req1_addr,
  input  logic [CACHE_WIDTH-1:0] req1_data,
  input  logic [MDATA-2:0]       req1_mdata,
  output logic                   req1_ready,
  output logic [1:0]             req1_done,
  output logic [CW-1:0]          req1_outst,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp0_valid,
  input  logic [MDATA-1:0]       wr_rsp0_mdata,
  input  logic                   wr_rsp1_valid,
  input  logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   idle,
  output logic                   err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic          last;
  logic          elig0, elig1;
  logic          win0, win1;
  logic [1:0]    cnt0, cnt1;
  logic [CW:0]   sum0, sum1;
  logic [CW:0]   ext0, ext1;
  logic          uflow0, uflow1;

  // On a tie the requester not granted most recently wins.
  always_comb begin
    elig0 = req0_valid && !wr_req_almostfull && (req0_outst < MAX_CNT);
    elig1 = req1_valid && !wr_req_almostfull && (req1_outst < MAX_CNT);
    win0  = elig0 && (!elig1 || last);
    win1  = elig1 && (!elig0 || !last);
  end

  assign req0_ready = win0;
  assign req1_ready = win1;

  always_comb begin
    cnt0   = {1'b0, wr_rsp0_valid && !wr_rsp0_mdata[MDATA-1]}
           + {1'b0, wr_rsp1_valid && !wr_rsp1_mdata[MDATA-1]};
    cnt1   = {1'b0, wr_rsp0_valid &&  wr_rsp0_mdata[MDATA-1]}
           + {1'b0, wr_rsp1_valid &&  wr_rsp1_mdata[MDATA-1]};
    sum0   = {1'b0, req0_outst} + (CW+1)'(win0);
    sum1   = {1'b0, req1_outst} + (CW+1)'(win1);
    ext0   = (CW+1)'(cnt0);
    ext1   = (CW+1)'(cnt1);
    uflow0 = ext0 > sum0;
    uflow1 = ext1 > sum1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_en    <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
      wr_req_mdata <= '0;
      last         <= 1'b1;
    end else begin
      wr_req_en <= win0 || win1;
      if (win0) begin
        wr_req_addr  <= req0_addr;
        wr_req_data  <= req0_data;
        wr_req_mdata <= {1'b0, req0_mdata};
      end else if (win1) begin
        wr_req_addr  <= req1_addr;
        wr_req_data  <= req1_data;
        wr_req_mdata <= {1'b1, req1_mdata};
      end else begin
        wr_req_addr  <= '0;
        wr_req_data  <= '0;
        wr_req_mdata <= '0;
      end
      if (win0 || win1)
        last <= win1;
    end
  end

  // A completion without a matching outstanding write clamps to zero and flags err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_outst <= '0;
      req1_outst <= '0;
      req0_done  <= '0;
      req1_done  <= '0;
      err        <= 1'b0;
    end else begin
      req0_done  <= cnt0;
      req1_done  <= cnt1;
      req0_outst <= uflow0 ? '0 : CW'(sum0 - ext0);
      req1_outst <= uflow1 ? '0 : CW'(sum1 - ext1);
      err        <= err || uflow0 || uflow1;
    end
  end

  assign idle = !wr_req_en && (req0_outst == '0) && (req1_outst == '0);

endmodule

// File: tb/tb_wr_req_arbiter.sv
// Randomized bench for wr_req_arbiter against an integer-level reference model.
module tb_wr_req_arbiter;

  localparam int MAX_OUT = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [19:0]  req0_addr, req1_addr;
  logic [511:0] req0_data, req1_data;
  logic [12:0]  req0_mdata, req1_mdata;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_done, req1_done;
  logic [3:0]   req0_outst, req1_outst;
  logic [19:0]  wr_req_addr;
  logic [13:0]  wr_req_mdata;
  logic [511:0] wr_req_data;
  logic         wr_req_en;
  logic         wr_req_almostfull;
  logic         wr_rsp0_valid, wr_rsp1_valid;
  logic [13:0]  wr_rsp0_mdata, wr_rsp1_mdata;
  logic         idle, err;

  int vectors = 0;
  int miscompares = 0;

  int           m_outst [2];
  int           m_done [2];
  int           m_last;
  logic         m_err;
  logic         m_en;
  logic [19:0]  m_addr;
  logic [13:0]  m_mdata;
  logic [511:0] m_data;
  logic         m_g0, m_g1;

  wr_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_mdata(req0_mdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_outst(req0_outst),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_mdata(req1_mdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_outst(req1_outst),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata),
    .wr_req_data(wr_req_data), .wr_req_en(wr_req_en),
    .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_outst[0] = 0; m_outst[1] = 0;
    m_done[0]  = 0; m_done[1]  = 0;
    m_last = 1; m_err = 1'b0; m_en = 1'b0;
    m_addr = '0; m_mdata = '0; m_data = '0;
    m_g0 = 1'b0; m_g1 = 1'b0;
  endtask

  task automatic clearInputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    req0_mdata = '0; req1_mdata = '0;
    wr_req_almostfull = 1'b0;
    wr_rsp0_valid = 1'b0; wr_rsp1_valid = 1'b0;
    wr_rsp0_mdata = '0; wr_rsp1_mdata = '0;
  endtask

  task automatic checkRegs();
    checkOutput("wr_req_en",    512'(wr_req_en),    512'(m_en));
    checkOutput("wr_req_addr",  512'(wr_req_addr),  512'(m_addr));
    checkOutput("wr_req_mdata", 512'(wr_req_mdata), 512'(m_mdata));
    checkOutput("wr_req_data",  wr_req_data,        m_data);
    checkOutput("req0_done",    512'(req0_done),    512'(m_done[0]));
    checkOutput("req1_done",    512'(req1_done),    512'(m_done[1]));
    checkOutput("req0_outst",   512'(req0_outst),   512'(m_outst[0]));
    checkOutput("req1_outst",   512'(req1_outst),   512'(m_outst[1]));
    checkOutput("err",          512'(err),          512'(m_err));
    checkOutput("idle",         512'(idle),
                512'(!m_en && m_outst[0] == 0 && m_outst[1] == 0));
  endtask

  function automatic logic [511:0] randLine();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // mode 0: legal responses, 1: no responses, 2: heavy legal drain, 3: unconstrained responses
  task automatic applyStimulus(input int mode, input int afPct);
    int avail [2];
    int g [2];
    int d [2];
    int sum;
    logic e0, e1;
    @(negedge clk);
    checkRegs();
    if (!req0_valid || m_g0) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_addr  = 20'($urandom());
      req0_mdata = 13'($urandom());
      req0_data  = randLine();
    end
    if (!req1_valid || m_g1) begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_addr  = 20'($urandom());
      req1_mdata = 13'($urandom());
      req1_data  = randLine();
    end
    wr_req_almostfull = ($urandom_range(0, 99) < afPct);
    avail[0] = m_outst[0];
    avail[1] = m_outst[1];
    for (int k = 0; k < 2; k++) begin
      logic v;
      int id;
      id = $urandom_range(0, 1);
      v  = 1'b0;
      if (mode == 3) v = ($urandom_range(0, 3) == 0);
      else if (mode != 1 && $urandom_range(0, 99) < (mode == 2 ? 80 : 35)) begin
        if (avail[id] == 0) id = 1 - id;
        if (avail[id] > 0) begin v = 1'b1; avail[id]--; end
      end
      if (k == 0) begin
        wr_rsp0_valid = v; wr_rsp0_mdata = {id[0], 13'($urandom())};
      end else begin
        wr_rsp1_valid = v; wr_rsp1_mdata = {id[0], 13'($urandom())};
      end
    end
    #1;
    e0 = req0_valid && !wr_req_almostfull && m_outst[0] < MAX_OUT;
    e1 = req1_valid && !wr_req_almostfull && m_outst[1] < MAX_OUT;
    g[0] = 0; g[1] = 0;
    if (e0 && e1) g[1 - m_last] = 1;
    else if (e0) g[0] = 1;
    else if (e1) g[1] = 1;
    checkOutput("req0_ready", 512'(req0_ready), 512'(g[0]));
    checkOutput("req1_ready", 512'(req1_ready), 512'(g[1]));
    d[0] = 0; d[1] = 0;
    if (wr_rsp0_valid) d[wr_rsp0_mdata[13]]++;
    if (wr_rsp1_valid) d[wr_rsp1_mdata[13]]++;
    for (int n = 0; n < 2; n++) begin
      sum = m_outst[n] + g[n];
      if (d[n] > sum) begin m_err = 1'b1; m_outst[n] = 0; end
      else m_outst[n] = sum - d[n];
      m_done[n] = d[n];
    end
    m_en = (g[0] + g[1]) > 0;
    if (g[0] == 1) begin
      m_addr = req0_addr; m_data = req0_data; m_mdata = {1'b0, req0_mdata};
    end else if (g[1] == 1) begin
      m_addr = req1_addr; m_data = req1_data; m_mdata = {1'b1, req1_mdata};
    end else begin
      m_addr = '0; m_data = '0; m_mdata = '0;
    end
    if (m_en) m_last = g[1];
    m_g0 = (g[0] == 1);
    m_g1 = (g[1] == 1);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    #1;
    checkRegs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    #12;
    checkRegs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) applyStimulus(0, 15);
    for (int i = 0; i < 40;  i++) applyStimulus(1, 5);
    for (int i = 0; i < 60;  i++) applyStimulus(2, 10);
    for (int i = 0; i < 30;  i++) applyStimulus(1, 0);
    asyncReset();
    for (int i = 0; i < 100; i++) applyStimulus(0, 20);
    for (int i = 0; i < 60;  i++) applyStimulus(3, 15);
    asyncReset();
    for (int i = 0; i < 100; i++) applyStimulus(0, 10);
    @(negedge clk);
    checkRegs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
